ysyx_23060208_axi_arbiter: RTL and testbench

YSYX_23060208_AXI_ARBITER -- requirements
Module: ysyx_23060208_axi_arbiter

---
 rtl/ysyx_23060208_axi_arbiter_if.sv | 29 ++
 rtl/ysyx_23060208_axi_arbiter.sv | 135 +++++++++++++
 tb/tb_ysyx_23060208_axi_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060208_axi_arbiter_if.sv
// One AXI4 read channel (AR + R); master drives requests, slave returns data.
// DATA_WIDTH is the address width; read data is 2*DATA_WIDTH wide.
interface ysyx_23060208_axi_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   araddr;
    logic [3:0]              arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    rvalid;
    logic                    rready;
    logic [2*DATA_WIDTH-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic [3:0]              rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_23060208_axi_arbiter.sv
// Two-requester AXI read arbiter (s0 = IFU, s1 = LSU) onto one downstream read channel.
// Latency: request seen in IDLE -> m_arvalid next cycle; owner held until rlast, then one IDLE cycle.
// Backpressure: arready/rready pass straight through for the owner only; ARB_RR_EN selects round-robin, else s1 wins.
module ysyx_23060208_axi_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    ysyx_23060208_axi_arbiter_if.slave  s0,
    ysyx_23060208_axi_arbiter_if.slave  s1,
    ysyx_23060208_axi_arbiter_if.master m,
    output logic [1:0]                  grant
);
    typedef enum logic [2:0] {IDLE, AR0, R0, AR1, R1} state_t;

    state_t state;
    state_t state_nxt;
    logic   pick_s1;
    logic   own_s1;

    logic                  sel_arvalid;
    logic [DATA_WIDTH-1:0] sel_araddr;
    logic [3:0]            sel_arid;
    logic [7:0]            sel_arlen;
    logic [2:0]            sel_arsize;
    logic [1:0]            sel_arburst;
    logic                  sel_rready;

    // Requester fields of whichever port currently owns the channel
    assign own_s1      = (state == AR1) || (state == R1);
    assign sel_arvalid = own_s1 ? s1.arvalid : s0.arvalid;
    assign sel_araddr  = own_s1 ? s1.araddr  : s0.araddr;
    assign sel_arid    = own_s1 ? s1.arid    : s0.arid;
    assign sel_arlen   = own_s1 ? s1.arlen   : s0.arlen;
    assign sel_arsize  = own_s1 ? s1.arsize  : s0.arsize;
    assign sel_arburst = own_s1 ? s1.arburst : s0.arburst;
    assign sel_rready  = own_s1 ? s1.rready  : s0.rready;

`ifdef ARB_RR_EN
    logic last_owner;  // 0 = s0, 1 = s1

    assign pick_s1 = s1.arvalid && (!s0.arvalid || !last_owner);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner <= 1'b0;
        end else if (state == IDLE && (s0.arvalid || s1.arvalid)) begin
            last_owner <= pick_s1;
        end
    end
`else
    assign pick_s1 = s1.arvalid;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant      = 2'b00;

        m.arvalid  = 1'b0;
        m.araddr   = '0;
        m.arid     = '0;
        m.arlen    = '0;
        m.arsize   = '0;
        m.arburst  = '0;
        m.rready   = 1'b0;

        s0.arready = 1'b0;
        s0.rvalid  = 1'b0;
        s0.rdata   = '0;
        s0.rresp   = '0;
        s0.rlast   = 1'b0;
        s0.rid     = '0;
        s1.arready = 1'b0;
        s1.rvalid  = 1'b0;
        s1.rdata   = '0;
        s1.rresp   = '0;
        s1.rlast   = 1'b0;
        s1.rid     = '0;

        case (state)
            IDLE: begin
                if (s0.arvalid || s1.arvalid) begin
                    state_nxt = pick_s1 ? AR1 : AR0;
                end
            end
            AR0, AR1: begin
                grant     = own_s1 ? 2'b10 : 2'b01;
                m.arvalid = sel_arvalid;
                m.araddr  = sel_araddr;
                m.arid    = sel_arid;
                m.arlen   = sel_arlen;
                m.arsize  = sel_arsize;
                m.arburst = sel_arburst;
                if (own_s1) begin
                    s1.arready = m.arready;
                end else begin
                    s0.arready = m.arready;
                end
                if (sel_arvalid && m.arready) begin
                    state_nxt = own_s1 ? R1 : R0;
                end
            end
            R0, R1: begin
                grant    = own_s1 ? 2'b10 : 2'b01;
                m.rready = sel_rready;
                // Response fields pass unchanged, error responses included
                if (own_s1) begin
                    s1.rvalid = m.rvalid;
                    s1.rdata  = m.rdata;
                    s1.rresp  = m.rresp;
                    s1.rlast  = m.rlast;
                    s1.rid    = m.rid;
                end else begin
                    s0.rvalid = m.rvalid;
                    s0.rdata  = m.rdata;
                    s0.rresp  = m.rresp;
                    s0.rlast  = m.rlast;
                    s0.rid    = m.rid;
                end
                if (m.rvalid && sel_rready && m.rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ysyx_23060208_axi_arbiter.sv
// Directed bench for the two-port AXI read arbiter with a transaction-level owner model and beat scoreboard.
module tb_ysyx_23060208_axi_arbiter;
    localparam int DW = 32;
`ifdef ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant;

    ysyx_23060208_axi_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
    ysyx_23060208_axi_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
    ysyx_23060208_axi_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

    ysyx_23060208_axi_arbiter #(.DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .s0    (s0_if),
        .s1    (s1_if),
        .m     (m_if),
        .grant (grant)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] gen(input logic [31:0] a, input int b);
        return {a + 32'(b) * 32'd8, 24'hC0FFEE, b[7:0]};
    endfunction

    function automatic int pick(input logic a0, input logic a1, input int last);
        if (a0 && a1) return (RR_MODE && last == 1) ? 0 : 1;
        return a1 ? 1 : 0;
    endfunction

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    beats[2];
    int    lasts[2];
    int    err_beats[2];
    int    ar_cycle[2];
    int    last_cycle[2];
    int    gorder[$];
    logic [1:0] prev_grant = 2'b00;

    // Transaction-level model: who owns the channel and whether its address was accepted
    int   mod_owner = -1;
    bit   mod_ad    = 1'b0;
    int   mod_last  = 0;
    int   cyc       = 0;
    bit   run_cmp   = 1'b0;

    // Downstream memory responder
    bit          rs_busy  = 1'b0;
    logic [31:0] rs_addr  = '0;
    logic [3:0]  rs_id    = '0;
    logic [7:0]  rs_len   = '0;
    int          rs_beat  = 0;
    logic [1:0]  rs_resp  = '0;
    logic [1:0]  resp_cfg = 2'b00;
    bit          spurious = 1'b0;

    always_comb begin
        m_if.rvalid = rs_busy || spurious;
        m_if.rdata  = rs_busy ? gen(rs_addr, rs_beat) : 64'hDEAD_BEEF_0BAD_F00D;
        m_if.rresp  = rs_busy ? rs_resp : 2'b11;
        m_if.rlast  = rs_busy ? (rs_beat == int'(rs_len)) : 1'b1;
        m_if.rid    = rs_busy ? rs_id : 4'hF;
    end

    initial begin
        bit          har;
        bit          hr;
        bit          rst_s;
        logic [31:0] a;
        logic [3:0]  id;
        logic [7:0]  ln;
        forever begin
            @(negedge clock);
            har   = m_if.arvalid && m_if.arready;
            hr    = m_if.rvalid && m_if.rready;
            rst_s = reset;
            a     = m_if.araddr;
            id    = m_if.arid;
            ln    = m_if.arlen;
            @(posedge clock);
            #1;
            if (rst_s) begin
                rs_busy = 1'b0;
            end else begin
                if (hr && rs_busy) begin
                    if (rs_beat == int'(rs_len)) rs_busy = 1'b0;
                    else rs_beat++;
                end
                if (har) begin
                    rs_busy = 1'b1;
                    rs_addr = a;
                    rs_id   = id;
                    rs_len  = ln;
                    rs_beat = 0;
                    rs_resp = resp_cfg;
                end
            end
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            mod_owner <= -1;
            mod_ad    <= 1'b0;
            mod_last  <= 0;
        end else if (mod_owner < 0) begin
            if (s0_if.arvalid || s1_if.arvalid) begin
                mod_owner <= pick(s0_if.arvalid, s1_if.arvalid, mod_last);
                mod_last  <= pick(s0_if.arvalid, s1_if.arvalid, mod_last);
                mod_ad    <= 1'b0;
            end
        end else if (!mod_ad) begin
            if ((mod_owner == 0 ? s0_if.arvalid : s1_if.arvalid) && m_if.arready) mod_ad <= 1'b1;
        end else if (m_if.rvalid && m_if.rlast && (mod_owner == 0 ? s0_if.rready : s1_if.rready)) begin
            mod_owner <= -1;
            mod_ad    <= 1'b0;
        end
    end

    task automatic mon_port(input int p, input logic arv, input logic ard, input logic [31:0] addr,
                            input logic [3:0] id, input logic [7:0] len, input logic rv, input logic rr,
                            input logic [63:0] rd, input logic [1:0] rs, input logic rl, input logic [3:0] ri);
        beat_t e;
        string nm;
        nm = (p == 0) ? "s0" : "s1";
        if (arv && ard) begin
            ar_cycle[p] = cyc;
            for (int b = 0; b <= int'(len); b++) begin
                e.data = gen(addr, b);
                e.resp = resp_cfg;
                e.last = (b == int'(len));
                e.id   = id;
                if (p == 0) exp_q0.push_back(e);
                else exp_q1.push_back(e);
            end
        end
        if (rv && rr) begin
            beats[p]++;
            if (rs == 2'b10) err_beats[p]++;
            if (rl) begin
                lasts[p]++;
                last_cycle[p] = cyc;
            end
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s_beat_unexpected actual=beat expected=none t=%0t", nm, $time);
            end else begin
                if (p == 0) e = exp_q0.pop_front();
                else e = exp_q1.pop_front();
                chk({nm, "_beat"}, {rd, rs, rl, ri}, {e.data, e.resp, e.last, e.id});
            end
        end
    endtask

    logic [1:0]  e_grant;
    logic [49:0] e_mar;
    logic        e_mrdy;
    logic [72:0] e_fwd;

    always @(negedge clock) begin
        if (run_cmp) begin
            e_grant = (mod_owner == 0) ? 2'b01 : (mod_owner == 1) ? 2'b10 : 2'b00;
            chk("grant", grant, e_grant);
            e_mar  = '0;
            e_mrdy = 1'b0;
            if (mod_owner == 0 && !mod_ad)
                e_mar = {s0_if.arvalid, s0_if.araddr, s0_if.arid, s0_if.arlen, s0_if.arsize, s0_if.arburst};
            if (mod_owner == 1 && !mod_ad)
                e_mar = {s1_if.arvalid, s1_if.araddr, s1_if.arid, s1_if.arlen, s1_if.arsize, s1_if.arburst};
            if (mod_ad) e_mrdy = (mod_owner == 0) ? s0_if.rready : s1_if.rready;
            chk("m_ar", {m_if.arvalid, m_if.araddr, m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst}, e_mar);
            chk("m_rready", m_if.rready, e_mrdy);
            e_fwd = mod_ad ? {1'b0, m_if.rvalid, m_if.rdata, m_if.rresp, m_if.rlast, m_if.rid}
                           : {m_if.arready, 72'b0};
            chk("s0_side", {s0_if.arready, s0_if.rvalid, s0_if.rdata, s0_if.rresp, s0_if.rlast, s0_if.rid},
                (mod_owner == 0) ? e_fwd : 73'b0);
            chk("s1_side", {s1_if.arready, s1_if.rvalid, s1_if.rdata, s1_if.rresp, s1_if.rlast, s1_if.rid},
                (mod_owner == 1) ? e_fwd : 73'b0);
        end
        mon_port(0, s0_if.arvalid, s0_if.arready, s0_if.araddr, s0_if.arid, s0_if.arlen,
                 s0_if.rvalid, s0_if.rready, s0_if.rdata, s0_if.rresp, s0_if.rlast, s0_if.rid);
        mon_port(1, s1_if.arvalid, s1_if.arready, s1_if.araddr, s1_if.arid, s1_if.arlen,
                 s1_if.rvalid, s1_if.rready, s1_if.rdata, s1_if.rresp, s1_if.rlast, s1_if.rid);
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
        end
        if (prev_grant == 2'b00 && grant != 2'b00) gorder.push_back(grant == 2'b10 ? 1 : 0);
        prev_grant = grant;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ar(input int p, input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] ln);
        if (p == 0) begin
            s0_if.arvalid = v; s0_if.araddr = a; s0_if.arid = id; s0_if.arlen = ln;
            s0_if.arsize = v ? 3'd3 : 3'd0; s0_if.arburst = v ? 2'b01 : 2'b00;
        end else begin
            s1_if.arvalid = v; s1_if.araddr = a; s1_if.arid = id; s1_if.arlen = ln;
            s1_if.arsize = v ? 3'd3 : 3'd0; s1_if.arburst = v ? 2'b01 : 2'b00;
        end
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic [3:0] id, input logic [7:0] ln);
        bit hs;
        hs = 1'b0;
        set_ar(p, 1'b1, a, id, ln);
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clock);
            hs = (p == 0) ? (s0_if.arvalid && s0_if.arready) : (s1_if.arvalid && s1_if.arready);
        end
        step();
        set_ar(p, 1'b0, 32'h0, 4'h0, 8'h0);
        chk("ar_handshake", hs, 1'b1);
    endtask

    task automatic read(input int p, input logic [31:0] a, input logic [3:0] id, input logic [7:0] ln);
        int l0;
        bit done;
        l0   = lasts[p];
        done = 1'b0;
        issue(p, a, id, ln);
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            #1;
            done = (lasts[p] != l0);
        end
        chk("rlast_seen", done, 1'b1);
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int e0;
        int first;
        set_ar(0, 1'b0, 32'h0, 4'h0, 8'h0);
        set_ar(1, 1'b0, 32'h0, 4'h0, 8'h0);
        s0_if.rready = 1'b1;
        s1_if.rready = 1'b1;
        m_if.arready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            beats[p] = 0; lasts[p] = 0; err_beats[p] = 0; ar_cycle[p] = 0; last_cycle[p] = 0;
        end

        step();
        run_cmp = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_grant", grant, 2'b00);
        chk("rst_m_arvalid", m_if.arvalid, 1'b0);
        chk("rst_m_rready", m_if.rready, 1'b0);
        chk("rst_s0_arready", s0_if.arready, 1'b0);
        chk("rst_s1_rvalid", s1_if.rvalid, 1'b0);
        step();

        // Single s0 burst, 4 beats, grant one cycle after request
        b0 = beats[0];
        fork
            read(0, 32'h8000_0000, 4'h1, 8'd3);
            begin
                step();
                chk("r029_grant", grant, 2'b01);
                chk("r029_m_arvalid", m_if.arvalid, 1'b1);
                chk("r029_m_araddr", m_if.araddr, 32'h8000_0000);
            end
        join
        chk("r029_beats", beats[0] - b0, 4);
        @(negedge clock);
        chk("r029_idle", grant, 2'b00);
        step();

        // Simultaneous requests, s1 owned the channel last
        read(1, 32'h0000_1000, 4'h2, 8'd0);
        gorder.delete();
        fork
            read(0, 32'h8000_0100, 4'h3, 8'd1);
            read(1, 32'h0000_2000, 4'h4, 8'd1);
        join
        first = RR_MODE ? 0 : 1;
        chk("r030_grants", gorder.size(), 2);
        if (gorder.size() >= 2) begin
            chk("r030_first", gorder[0], first);
            chk("r030_second", gorder[1], 1 - first);
        end
        chk("r030_gap", ar_cycle[1 - first] - last_cycle[first], 2);

        // s1 request during s0 data phase must wait for s0 rlast
        b0 = beats[0];
        fork
            read(0, 32'h8000_0200, 4'h5, 8'd3);
            begin
                for (int i = 0; i < 100 && beats[0] < b0 + 1; i++) begin
                    @(negedge clock);
                    #1;
                end
                step();
                read(1, 32'h0000_3000, 4'h6, 8'd0);
            end
        join
        chk("r031_gap", ar_cycle[1] - last_cycle[0], 2);

        // Error response forwarded on every s1 beat
        resp_cfg = 2'b10;
        e0 = err_beats[1];
        read(1, 32'h0000_4000, 4'h7, 8'd3);
        chk("r032_err_beats", err_beats[1] - e0, 4);
        resp_cfg = 2'b00;

        // s0 holds rready low for 5 cycles mid-burst
        b0 = beats[0];
        fork
            read(0, 32'h8000_0300, 4'h8, 8'd7);
            begin
                for (int i = 0; i < 100 && beats[0] < b0 + 2; i++) begin
                    @(negedge clock);
                    #1;
                end
                step();
                s0_if.rready = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    chk("r034_m_rready", m_if.rready, 1'b0);
                    chk("r034_m_rvalid_held", m_if.rvalid, 1'b1);
                end
                step();
                s0_if.rready = 1'b1;
            end
        join
        chk("r034_beats", beats[0] - b0, 8);
        chk("r034_leftover", exp_q0.size(), 0);

        // Stray m_rvalid in IDLE and during a stalled address phase
        spurious = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("r023_idle_s0_rvalid", s0_if.rvalid, 1'b0);
            chk("r023_idle_s1_rvalid", s1_if.rvalid, 1'b0);
            chk("r023_idle_grant", grant, 2'b00);
        end
        step();
        m_if.arready = 1'b0;
        fork
            read(1, 32'h0000_5000, 4'h9, 8'd1);
            begin
                repeat (3) begin
                    @(negedge clock);
                    chk("r023_ar_s1_rvalid", s1_if.rvalid, 1'b0);
                    chk("r023_ar_s1_arready", s1_if.arready, 1'b0);
                end
                step();
                m_if.arready = 1'b1;
            end
        join
        spurious = 1'b0;

        // Reset in the middle of an s0 burst, then a fresh request
        fork
            issue(0, 32'h8000_0400, 4'hA, 8'd3);
            begin
                for (int i = 0; i < 100 && s0_if.rvalid !== 1'b1; i++) begin
                    @(negedge clock);
                    #1;
                end
                step();
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
        join
        @(negedge clock);
        chk("r033_grant", grant, 2'b00);
        chk("r033_m_arvalid", m_if.arvalid, 1'b0);
        chk("r033_m_rready", m_if.rready, 1'b0);
        chk("r033_s0_rvalid", s0_if.rvalid, 1'b0);
        chk("r033_s1_rvalid", s1_if.rvalid, 1'b0);
        step();
        b0 = beats[0];
        read(0, 32'h8000_0500, 4'hB, 8'd1);
        chk("r026_beats", beats[0] - b0, 2);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
